fsk_tx_modulator: RTL and testbench



---
 rtl/fsk_tx_modulator.sv | 159 +++++++++++++++
 tb/tb_fsk_tx_modulator.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fsk_tx_modulator.sv
// fsk_tx_modulator: byte-serial framed FSK transmitter.
// Frame: start(0), 8 data bits LSB first, optional even parity, stop(1).
// Each frame bit lasts one bit_clk period; bit_clk is sampled as data.
// Build option: define FSK_TX_PARITY_EN to insert the even-parity bit.
//
// state   | meaning
// --------+-----------------------------------------------------
// IDLE    | line at mark, ready for a byte
// ARM     | byte latched, waiting for the next bit tick
// START   | sending start bit (0)
// DATA    | sending shift_reg[0], 8 bits LSB first
// PARITY  | sending even parity of the latched byte (optional)
// STOP    | sending stop bit (1)
module fsk_tx_modulator #(
  parameter logic [7:0] MARK_DIV  = 8'd2,
  parameter logic [7:0] SPACE_DIV = 8'd4
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       bit_clk,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       bit_out,
  output logic       fsk_out
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
`ifdef FSK_TX_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP   = 3'd5
  } state_t;

  state_t     state, state_nxt;
  logic       bit_clk_d;
  logic       bit_tick;
  logic [7:0] shift_reg, shift_nxt;
  logic [2:0] bit_idx, idx_nxt;
  logic [7:0] tone_cnt;
  logic [7:0] div;
  logic       tone_wrap;
`ifdef FSK_TX_PARITY_EN
  logic       parity_bit, parity_nxt;
`endif

  assign bit_tick = bit_clk & ~bit_clk_d;

  // Delay bit_clk by one cycle to find its rising edges.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) bit_clk_d <= 1'b0;
    else        bit_clk_d <= bit_clk;
  end

  // FSM state, shift register and bit index.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      shift_reg <= 8'd0;
      bit_idx   <= 3'd0;
`ifdef FSK_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      bit_idx   <= idx_nxt;
`ifdef FSK_TX_PARITY_EN
      parity_bit <= parity_nxt;
`endif
    end
  end

  // Next-state logic and line-bit / handshake outputs.
  always_comb begin
    state_nxt = state;
    shift_nxt = shift_reg;
    idx_nxt   = bit_idx;
`ifdef FSK_TX_PARITY_EN
    parity_nxt = parity_bit;
`endif
    tx_ready  = 1'b0;
    tx_busy   = 1'b1;
    bit_out   = 1'b1;
    case (state)
      S_IDLE: begin
        tx_ready = 1'b1;
        tx_busy  = 1'b0;
        if (tx_valid) begin
          shift_nxt = tx_data;
          idx_nxt   = 3'd0;
`ifdef FSK_TX_PARITY_EN
          parity_nxt = ^tx_data;
`endif
          state_nxt = S_ARM;
        end
      end
      S_ARM: begin
        if (bit_tick) state_nxt = S_START;
      end
      S_START: begin
        bit_out = 1'b0;
        if (bit_tick) begin
          idx_nxt   = 3'd0;
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        bit_out = shift_reg[0];
        if (bit_tick) begin
          shift_nxt = {1'b0, shift_reg[7:1]};
          idx_nxt   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef FSK_TX_PARITY_EN
            state_nxt = S_PARITY;
`else
            state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef FSK_TX_PARITY_EN
      S_PARITY: begin
        bit_out = parity_bit;
        if (bit_tick) state_nxt = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_tick) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Compare in 9 bits so tone_cnt + 1 cannot wrap; div of 0 or 1 toggles every cycle.
  assign div       = bit_out ? MARK_DIV : SPACE_DIV;
  assign tone_wrap = ({1'b0, tone_cnt} + 9'd1) >= {1'b0, div};

  // Free-running tone; a bit_out change keeps counter and phase (phase-continuous).
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_cnt <= 8'd0;
      fsk_out  <= 1'b0;
    end else if (tone_wrap) begin
      tone_cnt <= 8'd0;
      fsk_out  <= ~fsk_out;
    end else begin
      tone_cnt <= tone_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_fsk_tx_modulator.sv
// Directed bench for fsk_tx_modulator; expected frames built from the byte value.
module tb_fsk_tx_modulator;

`ifdef FSK_TX_PARITY_EN
  localparam int N = 11;
`else
  localparam int N = 10;
`endif

  logic       sys_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_clk = 1'b0;
  logic [7:0] tx_data = 8'd0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_busy, bit_out, fsk_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cyc = -100;
  int bc_cnt = 0;
  logic bc_run = 1'b1;

  fsk_tx_modulator dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bit_clk (bit_clk),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_busy (tx_busy),
    .bit_out (bit_out),
    .fsk_out (fsk_out)
  );

  always #5 sys_clk = ~sys_clk;

  // bit_clk: 32 sys_clk period, 16 high, generated synchronously; can be stalled.
  always @(posedge sys_clk) begin
    cyc <= cyc + 1;
    if (bc_run) begin
      if (bc_cnt == 31) begin
        bc_cnt   <= 0;
        bit_clk  <= 1'b1;
        rise_cyc <= cyc + 1;
      end else begin
        bc_cnt <= bc_cnt + 1;
        if (bc_cnt == 15) bit_clk <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    logic [10:0] f;
    f = 11'h7FF;
    f[0] = 1'b0;
    f[8:1] = d;
`ifdef FSK_TX_PARITY_EN
    f[9] = ^d;
    f[10] = 1'b1;
`else
    f[9] = 1'b1;
`endif
    return f;
  endfunction

  task automatic send_byte(input logic [7:0] d);
    @(negedge sys_clk);
    chk("ready_before_send", tx_ready, 1'b1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge sys_clk);
    tx_valid = 1'b0;
    chk("ready_low_after_accept", tx_ready, 1'b0);
    chk("busy_high_after_accept", tx_busy, 1'b1);
  endtask

  task automatic wait_start(output int s);
    int n;
    n = 0;
    while (bit_out !== 1'b0 && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    chk("start_seen", bit_out, 1'b0);
    s = (bit_out === 1'b0) ? cyc : -1;
  endtask

  task automatic capture_frame(input logic [7:0] d, output int s_start);
    logic [10:0] ef;
    int tog[11];
    bit held_ok[11];
    bit busy_ok;
    int last_tog, min_gap;
    logic prev_fsk;
    ef = exp_frame(d);
    wait_start(s_start);
    if (s_start < 0) return;
    chk("start_1cyc_after_bitclk_rise", cyc - rise_cyc, 1);
    for (int b = 0; b < 11; b++) begin
      tog[b] = 0;
      held_ok[b] = 1'b1;
    end
    busy_ok = 1'b1;
    last_tog = -1;
    min_gap = 1000;
    prev_fsk = fsk_out;
    for (int k = 1; k <= 32 * N; k++) begin
      @(negedge sys_clk);
      if (fsk_out !== prev_fsk) begin
        tog[(k - 1) / 32]++;
        if (last_tog >= 0 && (k - last_tog) < min_gap) min_gap = k - last_tog;
        last_tog = k;
      end
      prev_fsk = fsk_out;
      if (k < 32 * N) begin
        if (bit_out !== ef[k / 32]) held_ok[k / 32] = 1'b0;
        if (tx_busy !== 1'b1) busy_ok = 1'b0;
      end
    end
    for (int b = 0; b < N; b++) begin
      chk($sformatf("byte%h_bit%0d_level", d, b), held_ok[b], 1'b1);
      chk($sformatf("byte%h_bit%0d_toggles", d, b), tog[b], ef[b] ? 16 : 8);
    end
    chk("min_toggle_gap_ge_2", (min_gap >= 2), 1'b1);
    chk("busy_through_frame", busy_ok, 1'b1);
    chk("line_idle_after_stop", bit_out, 1'b1);
    chk("busy_low_after_stop", tx_busy, 1'b0);
    chk("ready_after_stop", tx_ready, 1'b1);
  endtask

  initial begin
    int s1, s2, s3, tg;
    bit ok, no_tog;
    logic pf;

    // Reset held with bit_clk running.
    ok = 1'b1;
    no_tog = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge sys_clk);
      if (tx_ready !== 1'b1 || tx_busy !== 1'b0 || bit_out !== 1'b1) ok = 1'b0;
      if (fsk_out !== 1'b0) no_tog = 1'b0;
    end
    chk("reset_outputs", ok, 1'b1);
    chk("reset_no_fsk_toggle", no_tog, 1'b1);
    chk("reset_tx_ready", tx_ready, 1'b1);
    chk("reset_bit_out", bit_out, 1'b1);

    // Release: mark tone toggles every 2 cycles.
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge sys_clk);
      chk($sformatf("mark_tone_cyc%0d", k), fsk_out, (k >> 1) & 1);
    end

    send_byte(8'hA5);
    capture_frame(8'hA5, s1);
    send_byte(8'h07);
    capture_frame(8'h07, s1);
    send_byte(8'h03);
    capture_frame(8'h03, s1);

    // Back-to-back with tx_valid held high, then busy-time pulses ignored.
    @(negedge sys_clk);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    @(negedge sys_clk);
    chk("b2b_first_accepted", tx_busy, 1'b1);
    tx_data = 8'hAA;
    capture_frame(8'h55, s1);
    @(negedge sys_clk);
    chk("b2b_second_accepted", tx_ready, 1'b0);
    tx_valid = 1'b0;
    fork
      capture_frame(8'hAA, s2);
      begin
        repeat (100) @(negedge sys_clk);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        repeat (3) @(negedge sys_clk);
        tx_valid = 1'b0;
        repeat (100) @(negedge sys_clk);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        repeat (2) @(negedge sys_clk);
        tx_valid = 1'b0;
      end
    join
    chk("b2b_one_idle_bit", s2 - (s1 + 32 * N), 32);
    ok = 1'b1;
    for (int i = 0; i < 150; i++) begin
      @(negedge sys_clk);
      if (bit_out !== 1'b1 || tx_busy !== 1'b0) ok = 1'b0;
    end
    chk("no_third_frame", ok, 1'b1);

    // bit_clk stalled during the start bit: state holds, tone keeps running.
    send_byte(8'h5A);
    wait_start(s3);
    bc_run = 1'b0;
    ok = 1'b1;
    tg = 0;
    pf = fsk_out;
    for (int i = 0; i < 100; i++) begin
      @(negedge sys_clk);
      if (bit_out !== 1'b0 || tx_busy !== 1'b1) ok = 1'b0;
      if (fsk_out !== pf) tg++;
      pf = fsk_out;
    end
    chk("stall_holds_start_bit", ok, 1'b1);
    chk("stall_space_toggles", tg, 25);
    bc_run = 1'b1;
    for (int i = 0; i < 32 * 12 + 64 && tx_busy !== 1'b0; i++) @(negedge sys_clk);
    chk("stall_frame_completes", tx_busy, 1'b0);

    // Reset in the middle of the 4th data bit.
    send_byte(8'hC3);
    wait_start(s3);
    repeat (32 * 4 + 16) @(negedge sys_clk);
    chk("pre_reset_data3", bit_out, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_bit_out", bit_out, 1'b1);
    chk("midreset_busy", tx_busy, 1'b0);
    chk("midreset_ready", tx_ready, 1'b1);
    chk("midreset_fsk", fsk_out, 1'b0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    send_byte(8'h3C);
    capture_frame(8'h3C, s1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
